// File: rtl/riscv_mprf_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional live write-to-read bypass is enabled by defining RISCV_MPRF_BYPASS_EN.
package riscv_mprf_pkg;

    localparam int unsigned XLEN_DEF    = 64;
    localparam int unsigned NREGS_DEF   = 32;
    localparam int unsigned NRD_DEF     = 2;
    localparam int unsigned NWR_DEF     = 2;
    localparam int unsigned SP_IDX_DEF  = 2;
    localparam logic [63:0] SP_INIT_DEF = 64'h0000_0000_7FFF_FFF0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mprf_state_e;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/riscv_mprf_if.sv
// Port bundle of the register file: write ports, read ports, scoreboard alloc and status.
// Handshake: none; every input is sampled on the falling clock edge, reads are combinational.
interface riscv_mprf_if
    import riscv_mprf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NRD  = NRD_DEF,
    parameter int unsigned NWR  = NWR_DEF,
    parameter int unsigned AW   = addr_width(NREGS_DEF)
) ();

    logic [NWR-1:0]      i_riscv_mprf_regwrite;
    logic [NWR*AW-1:0]   i_riscv_mprf_rdaddr;
    logic [NWR*XLEN-1:0] i_riscv_mprf_rddata;
    logic [NRD*AW-1:0]   i_riscv_mprf_rsaddr;
    logic [NRD*XLEN-1:0] o_riscv_mprf_rsdata;
    logic [NRD-1:0]      o_riscv_mprf_rsbusy;
    logic                i_riscv_mprf_alloc_en;
    logic [AW-1:0]       i_riscv_mprf_alloc_addr;
    logic                o_riscv_mprf_ready;
    mprf_state_e         o_riscv_mprf_state;

    modport master (
        output i_riscv_mprf_regwrite, i_riscv_mprf_rdaddr, i_riscv_mprf_rddata,
        output i_riscv_mprf_rsaddr, i_riscv_mprf_alloc_en, i_riscv_mprf_alloc_addr,
        input  o_riscv_mprf_rsdata, o_riscv_mprf_rsbusy, o_riscv_mprf_ready,
        input  o_riscv_mprf_state
    );

    modport slave (
        input  i_riscv_mprf_regwrite, i_riscv_mprf_rdaddr, i_riscv_mprf_rddata,
        input  i_riscv_mprf_rsaddr, i_riscv_mprf_alloc_en, i_riscv_mprf_alloc_addr,
        output o_riscv_mprf_rsdata, o_riscv_mprf_rsbusy, o_riscv_mprf_ready,
        output o_riscv_mprf_state
    );

endinterface

// File: rtl/riscv_mprf_scoreboard.sv
// Per-register busy bits: set by decode allocation, released by writeback.
// Allocation beats a same-edge release so a newly issued producer is never lost.
module riscv_mprf_scoreboard
    import riscv_mprf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = NWR_DEF,
    parameter int unsigned AW    = addr_width(NREGS_DEF)
) (
    input  logic              i_clk_n,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_alloc_en,
    input  logic [AW-1:0]     i_alloc_addr,
    input  logic [NWR-1:0]    i_regwrite,
    input  logic [NWR*AW-1:0] i_rdaddr,
    output logic [NREGS-1:0]  o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_en) begin
            for (int w = 0; w < NWR; w++) begin
                if (i_regwrite[w]) begin
                    w_busy_nxt[i_rdaddr[w*AW +: AW]] = 1'b0;
                end
            end
            if (i_alloc_en) begin
                w_busy_nxt[i_alloc_addr] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(negedge i_clk_n) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/riscv_mprf.sv
// Multi-port integer register file with busy scoreboard and post-reset clear sequence.
// Define RISCV_MPRF_BYPASS_EN to forward same-cycle write data to the read ports.
module riscv_mprf
    import riscv_mprf_pkg::*;
#(
    parameter int unsigned      XLEN    = XLEN_DEF,
    parameter int unsigned      NREGS   = NREGS_DEF,
    parameter int unsigned      NRD     = NRD_DEF,
    parameter int unsigned      NWR     = NWR_DEF,
    parameter int unsigned      SP_IDX  = SP_IDX_DEF,
    parameter logic [XLEN-1:0]  SP_INIT = SP_INIT_DEF[XLEN-1:0],
    localparam int unsigned     AW      = addr_width(NREGS)
) (
    input  logic        i_riscv_mprf_clk_n,
    input  logic        i_riscv_mprf_rst,
    riscv_mprf_if.slave bus
);

    mprf_state_e      r_state;
    mprf_state_e      w_state_nxt;
    logic [AW-1:0]    r_clr_cnt;
    logic [AW-1:0]    w_clr_cnt_nxt;
    logic [XLEN-1:0]  r_rf [NREGS];

    logic [AW-1:0]    w_wdaddr [NWR];
    logic [XLEN-1:0]  w_wddata [NWR];
    logic [AW-1:0]    w_rsaddr [NRD];
    logic [NREGS-1:0] w_wr_en;
    logic [XLEN-1:0]  w_wr_data [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_ready;

    logic [NRD*XLEN-1:0] w_rsdata_flat;
    logic [NRD-1:0]      w_rsbusy;

    assign w_ready = (r_state == READY);

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            w_wdaddr[w] = bus.i_riscv_mprf_rdaddr[w*AW +: AW];
            w_wddata[w] = bus.i_riscv_mprf_rddata[w*XLEN +: XLEN];
        end
        for (int r = 0; r < NRD; r++) begin
            w_rsaddr[r] = bus.i_riscv_mprf_rsaddr[r*AW +: AW];
        end
    end

    // Clear FSM: one register per edge, the last index hands over to READY.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = READY;
                end
            end
            default: begin
                w_state_nxt   = READY;
                w_clr_cnt_nxt = r_clr_cnt;
            end
        endcase
    end

    always_ff @(negedge i_riscv_mprf_clk_n) begin
        if (i_riscv_mprf_rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Ascending port scan: a later port overrides an earlier one on the same address.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_wr_en[i]   = 1'b0;
            w_wr_data[i] = '0;
        end
        if (!i_riscv_mprf_rst) begin
            if (r_state == CLEAR) begin
                w_wr_en[r_clr_cnt]   = 1'b1;
                w_wr_data[r_clr_cnt] = (r_clr_cnt == AW'(SP_IDX)) ? SP_INIT : '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (bus.i_riscv_mprf_regwrite[w] && (w_wdaddr[w] != '0)) begin
                        w_wr_en[w_wdaddr[w]]   = 1'b1;
                        w_wr_data[w_wdaddr[w]] = w_wddata[w];
                    end
                end
            end
        end
    end

    always_ff @(negedge i_riscv_mprf_clk_n) begin
        for (int i = 0; i < NREGS; i++) begin
            if (w_wr_en[i]) begin
                r_rf[i] <= w_wr_data[i];
            end
        end
    end

    riscv_mprf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk_n      (i_riscv_mprf_clk_n),
        .i_rst        (i_riscv_mprf_rst),
        .i_en         (w_ready),
        .i_alloc_en   (bus.i_riscv_mprf_alloc_en),
        .i_alloc_addr (bus.i_riscv_mprf_alloc_addr),
        .i_regwrite   (bus.i_riscv_mprf_regwrite),
        .i_rdaddr     (bus.i_riscv_mprf_rdaddr),
        .o_busy       (w_busy)
    );

    // Reads return zero while clearing and for x0; the stored array is otherwise not trusted.
    always_comb begin
        w_rsdata_flat = '0;
        w_rsbusy      = '0;
        for (int r = 0; r < NRD; r++) begin
            if (w_ready && (w_rsaddr[r] != '0)) begin
                w_rsdata_flat[r*XLEN +: XLEN] = r_rf[w_rsaddr[r]];
                w_rsbusy[r]                   = w_busy[w_rsaddr[r]];
`ifdef RISCV_MPRF_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (bus.i_riscv_mprf_regwrite[w] && (w_wdaddr[w] == w_rsaddr[r])) begin
                        w_rsdata_flat[r*XLEN +: XLEN] = w_wddata[w];
                        w_rsbusy[r]                   = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.o_riscv_mprf_rsdata = w_rsdata_flat;
    assign bus.o_riscv_mprf_rsbusy = w_rsbusy;
    assign bus.o_riscv_mprf_ready  = w_ready;
    assign bus.o_riscv_mprf_state  = r_state;

endmodule

// File: tb/tb_riscv_mprf.sv
// Bench for riscv_mprf: directed scenarios with literal expectations plus a randomized run
// checked every cycle against an array-based model of the register file.
module tb_riscv_mprf;
  import riscv_mprf_pkg::*;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int AW     = 5;
  localparam int SP_IDX = 2;
  localparam logic [63:0] SP_INIT = 64'h0000_0000_7FFF_FFF0;

  // ---------------- clock / reset ----------------
  logic clk_n = 1'b1;
  logic rst   = 1'b1;
  always #5 clk_n = ~clk_n;

  riscv_mprf_if #(.XLEN(XLEN), .NRD(NRD), .NWR(NWR), .AW(AW)) u_if ();

  riscv_mprf #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
  ) dut (
    .i_riscv_mprf_clk_n (clk_n),
    .i_riscv_mprf_rst   (rst),
    .bus                (u_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_rf [NREGS];
  bit              m_busy [NREGS];
  bit              m_ready = 1'b0;
  bit              m_valid = 1'b0;
  int              m_edges = 0;

  function automatic int wr_addr(int w);
    return int'(u_if.i_riscv_mprf_rdaddr[w*AW +: AW]);
  endfunction
  function automatic logic [XLEN-1:0] wr_data(int w);
    return u_if.i_riscv_mprf_rddata[w*XLEN +: XLEN];
  endfunction
  function automatic int rd_addr(int r);
    return int'(u_if.i_riscv_mprf_rsaddr[r*AW +: AW]);
  endfunction

  // Clear takes NREGS edges after reset; register k is loaded on edge k+1.
  always @(negedge clk_n) begin
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_edges = 0;
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_rf[m_edges] = (m_edges == SP_IDX) ? SP_INIT : 64'd0;
        m_edges++;
        if (m_edges == NREGS) m_ready = 1'b1;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (u_if.i_riscv_mprf_regwrite[w]) begin
            if (wr_addr(w) != 0) m_rf[wr_addr(w)] = wr_data(w);
            m_busy[wr_addr(w)] = 1'b0;
          end
        end
        if (u_if.i_riscv_mprf_alloc_en && u_if.i_riscv_mprf_alloc_addr != 0)
          m_busy[u_if.i_riscv_mprf_alloc_addr] = 1'b1;
        m_busy[0] = 1'b0;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_data(int r);
    logic [XLEN-1:0] d;
    int a;
    a = rd_addr(r);
    if (!m_ready || a == 0) return '0;
    d = m_rf[a];
`ifdef RISCV_MPRF_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (u_if.i_riscv_mprf_regwrite[w] && wr_addr(w) == a) d = wr_data(w);
`endif
    return d;
  endfunction

  function automatic logic exp_busy(int r);
    logic b;
    int a;
    a = rd_addr(r);
    if (!m_ready || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef RISCV_MPRF_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (u_if.i_riscv_mprf_regwrite[w] && wr_addr(w) == a) b = 1'b0;
`endif
    return b;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk_n) begin
    if (m_valid) begin
      chk("ready", {63'd0, u_if.o_riscv_mprf_ready}, {63'd0, m_ready});
      chk("state", {63'd0, u_if.o_riscv_mprf_state == READY}, {63'd0, m_ready});
      for (int r = 0; r < NRD; r++) begin
        chk($sformatf("rsdata%0d", r), u_if.o_riscv_mprf_rsdata[r*XLEN +: XLEN], exp_data(r));
        chk($sformatf("rsbusy%0d", r), {63'd0, u_if.o_riscv_mprf_rsbusy[r]}, {63'd0, exp_busy(r)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_n);
    #1;
  endtask

  task automatic idle();
    u_if.i_riscv_mprf_regwrite = '0;
    u_if.i_riscv_mprf_alloc_en = 1'b0;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    u_if.i_riscv_mprf_regwrite[w]         = 1'b1;
    u_if.i_riscv_mprf_rdaddr[w*AW +: AW]  = a;
    u_if.i_riscv_mprf_rddata[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    u_if.i_riscv_mprf_rsaddr[r*AW +: AW] = a;
  endtask

  task automatic clear_seq(input string tag);
    for (int i = 1; i <= NREGS; i++) begin
      step();
      chk(tag, {63'd0, u_if.o_riscv_mprf_ready}, {63'd0, (i == NREGS)});
    end
  endtask

  function automatic logic [XLEN-1:0] pat(int a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h0000_0001_0001);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] old7;
    idle();
    u_if.i_riscv_mprf_rdaddr   = '0;
    u_if.i_riscv_mprf_rddata   = '0;
    u_if.i_riscv_mprf_rsaddr   = '0;
    u_if.i_riscv_mprf_alloc_addr = '0;
    set_rd(0, 5'd2);
    set_rd(1, 5'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_ready", {63'd0, u_if.o_riscv_mprf_ready}, 64'd0);
    chk("rst_rsdata", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'd0);
    chk("rst_rsbusy", {62'd0, u_if.o_riscv_mprf_rsbusy}, 64'd0);

    // 1: clear sequence
    clear_seq("clear_ready");
    chk("sp_init", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'h0000_0000_7FFF_FFF0);
    chk("r3_zero", u_if.o_riscv_mprf_rsdata[2*XLEN-1:XLEN], 64'd0);

    // 2: reset in the middle of clear restarts the count
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    clear_seq("restart_ready");

    // 3: same-address conflict and x0 write
    set_wr(0, 5'd5, 64'hAA);
    set_wr(1, 5'd5, 64'hBB);
    step(); idle();
    set_rd(0, 5'd5);
    #1 chk("conflict_hi_wins", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'hBB);
    set_wr(0, 5'd0, 64'hFF);
    step(); idle();
    set_rd(0, 5'd0);
    #1 chk("x0_zero", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'd0);

    // 4: scoreboard alloc / release / priority
    u_if.i_riscv_mprf_alloc_en = 1'b1; u_if.i_riscv_mprf_alloc_addr = 5'd7;
    step(); idle();
    set_rd(0, 5'd7);
    #1 chk("alloc_busy", {63'd0, u_if.o_riscv_mprf_rsbusy[0]}, 64'd1);
    set_wr(0, 5'd7, 64'h1111);
    step(); idle();
    #1 chk("release_busy", {63'd0, u_if.o_riscv_mprf_rsbusy[0]}, 64'd0);
    chk("release_data", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'h1111);
    u_if.i_riscv_mprf_alloc_en = 1'b1; u_if.i_riscv_mprf_alloc_addr = 5'd7;
    set_wr(1, 5'd7, 64'h2222);
    step(); idle();
    #1 chk("alloc_beats_release", {63'd0, u_if.o_riscv_mprf_rsbusy[0]}, 64'd1);
    chk("alloc_write_data", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'h2222);

    // 5: write and read the same register in one cycle
    old7 = 64'h2222;
    set_wr(0, 5'd7, 64'hF);
    #1;
`ifdef RISCV_MPRF_BYPASS_EN
    chk("bypass_data", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'hF);
    chk("bypass_busy", {63'd0, u_if.o_riscv_mprf_rsbusy[0]}, 64'd0);
`else
    chk("nobypass_data", u_if.o_riscv_mprf_rsdata[XLEN-1:0], old7);
    chk("nobypass_busy", {63'd0, u_if.o_riscv_mprf_rsbusy[0]}, 64'd1);
`endif
    step(); idle();
    #1 chk("after_edge_data", u_if.o_riscv_mprf_rsdata[XLEN-1:0], 64'hF);
    chk("after_edge_busy", {63'd0, u_if.o_riscv_mprf_rsbusy[0]}, 64'd0);

    // 6: fill every register, then sweep through every read port
    for (int a = 0; a < NREGS; a += 2) begin
      set_wr(0, AW'(a), pat(a));
      set_wr(1, AW'(a + 1), pat(a + 1));
      step();
    end
    idle();
    for (int a = 0; a < NREGS; a++) begin
      for (int r = 0; r < NRD; r++) set_rd(r, AW'((a + 7 * r) % NREGS));
      #1;
      for (int r = 0; r < NRD; r++)
        chk($sformatf("sweep_p%0d", r), u_if.o_riscv_mprf_rsdata[r*XLEN +: XLEN],
            (((a + 7 * r) % NREGS) == 0) ? 64'd0 : pat((a + 7 * r) % NREGS));
      step();
    end

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int w = 0; w < NWR; w++) begin
        u_if.i_riscv_mprf_regwrite[w] = ($urandom_range(0, 2) == 0);
        u_if.i_riscv_mprf_rdaddr[w*AW +: AW] =
          $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
        u_if.i_riscv_mprf_rddata[w*XLEN +: XLEN] = {$urandom(), $urandom()};
      end
      u_if.i_riscv_mprf_alloc_en   = ($urandom_range(0, 2) == 0);
      u_if.i_riscv_mprf_alloc_addr = AW'($urandom_range(0, 7));
      for (int r = 0; r < NRD; r++)
        set_rd(r, $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1)));
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
